// File: rtl/spi_prefetch_fifo_if.sv
// spi_prefetch_fifo_if: handshake bundle between the flash controller, the prefetch FIFO and its consumer
//   master: drives start_read, stop_read, spi_data, spi_busy, pop; observes the FIFO outputs
//   slave : the FIFO; drives spi_continue, data_out, empty, full, level, underflow
interface spi_prefetch_fifo_if #(
   parameter int DATA_WIDTH_BYTES = 2,
   parameter int DEPTH = 4,
   parameter int LW = $clog2(DEPTH + 1)
);
   localparam int W = 8 * DATA_WIDTH_BYTES;
   logic start_read, stop_read, spi_busy, spi_continue, pop, empty, full, underflow;
   logic [W-1:0] spi_data, data_out;
   logic [LW-1:0] level;
   modport master (
      output start_read, stop_read, spi_data, spi_busy, pop,
      input spi_continue, data_out, empty, full, level, underflow
   );
   modport slave (
      input start_read, stop_read, spi_data, spi_busy, pop,
      output spi_continue, data_out, empty, full, level, underflow
   );
endinterface

// File: rtl/spi_prefetch_fifo.sv
// spi_prefetch_fifo: DEPTH-entry prefetch ring buffer between the SPI flash controller and the RLE consumer
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : slave side of spi_prefetch_fifo_if (start/stop, controller data/busy/continue,
//               consumer pop/data_out, status empty/full/level/underflow)
module spi_prefetch_fifo #(
   parameter int DATA_WIDTH_BYTES = 2,
   parameter int DEPTH = 4,
   parameter int LW = $clog2(DEPTH + 1)
) (
   input logic clk,
   input logic rstn,
   spi_prefetch_fifo_if.slave bus
);
   localparam int W = 8 * DATA_WIDTH_BYTES;
   localparam int PW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;
   state_t state, state_nx;
   logic [W-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
   logic [LW-1:0] level, level_nx;
   logic [LW:0] occ;
   logic [W-1:0] data_out, data_out_nx;
   logic underflow, underflow_nx, empty, full;
   logic flush, push, do_pop, issue;
   always_comb begin
      flush = bus.start_read | bus.stop_read;
      push = (state == WAIT) & ~bus.spi_busy & ~flush;
      do_pop = bus.pop & ~flush & (level != '0);
      occ = {1'b0, level} + (LW+1)'(push) - (LW+1)'(do_pop);
      // the word requested now is reserved by requiring room after this cycle's push/pop
      issue = (state == READY) & ~flush & (occ < (LW+1)'(DEPTH));
      state_nx = bus.stop_read ? IDLE : bus.start_read ? WAIT : push ? READY : issue ? WAIT : state;
      wr_ptr_nx = flush ? '0 : wr_ptr + PW'(push);
      rd_ptr_nx = flush ? '0 : rd_ptr + PW'(do_pop);
      level_nx = flush ? '0 : occ[LW-1:0];
      underflow_nx = (bus.start_read & ~bus.stop_read) ? 1'b0 : underflow | (bus.pop & ~flush & (level == '0));
      // bypass the word being written when it becomes the new head
      data_out_nx = (push & (wr_ptr == rd_ptr_nx)) ? bus.spi_data : mem[rd_ptr_nx];
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         data_out <= '0;
         underflow <= 1'b0;
         empty <= 1'b1;
         full <= 1'b0;
      end else begin
         state <= state_nx;
         wr_ptr <= wr_ptr_nx;
         rd_ptr <= rd_ptr_nx;
         level <= level_nx;
         data_out <= data_out_nx;
         underflow <= underflow_nx;
         empty <= (level_nx == '0);
         full <= (level_nx == LW'(DEPTH));
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.spi_data;
   end
   assign bus.spi_continue = issue;
   assign bus.data_out = data_out;
   assign bus.empty = empty;
   assign bus.full = full;
   assign bus.level = level;
   assign bus.underflow = underflow;
endmodule

// File: tb/tb_spi_prefetch_fifo.sv
// tb_spi_prefetch_fifo: directed bench for spi_prefetch_fifo with a cycle-level flash controller model
module tb_spi_prefetch_fifo;
   logic clk = 1'b0;
   logic rstn = 1'b1;
   logic clk_en = 1'b1;
   always #5 clk = clk_en ? ~clk : clk;
   spi_prefetch_fifo_if #(.DATA_WIDTH_BYTES(2), .DEPTH(4)) bus ();
   spi_prefetch_fifo #(.DATA_WIDTH_BYTES(2), .DEPTH(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));
   int passed = 0;
   int total = 0;
   int lat = 1;
   int cnt = 0;
   int remaining = 0;
   int cont_cnt = 0;
   logic [15:0] next_data = 16'h0;
   logic [15:0] data_inc = 16'h0;
   logic delivered = 1'b0;

   // one clock cycle: sample requests before the edge, advance the controller model after it
   task automatic step();
      logic req;
      #1;
      req = bus.start_read | bus.spi_continue;
      if (bus.spi_continue) cont_cnt++;
      @(posedge clk);
      @(negedge clk);
      delivered = 1'b0;
      if (bus.spi_busy && cnt > 0) begin
         cnt--;
         if (cnt == 0 && remaining > 0) begin
            bus.spi_busy = 1'b0;
            bus.spi_data = next_data;
            next_data = next_data + data_inc;
            remaining--;
            delivered = 1'b1;
         end
      end
      if (req) begin
         bus.spi_busy = 1'b1;
         cnt = lat;
      end
   endtask

   task automatic do_stop();
      bus.stop_read = 1'b1;
      step();
      bus.stop_read = 1'b0;
   endtask

   task automatic do_start();
      bus.start_read = 1'b1;
      step();
      bus.start_read = 1'b0;
   endtask

   task automatic test_reset();
      #1 rstn = 1'b0;
      step();
      step();
      total++; if (bus.level !== 3'd0) $display("FAIL reset_level: got %0d want 0", bus.level); else passed++;
      total++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty); else passed++;
      total++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else passed++;
      total++; if (bus.data_out !== 16'h0) $display("FAIL reset_data: got %h want 0000", bus.data_out); else passed++;
      total++; if (bus.underflow !== 1'b0) $display("FAIL reset_underflow: got %b want 0", bus.underflow); else passed++;
      total++; if (bus.spi_continue !== 1'b0) $display("FAIL reset_continue: got %b want 0", bus.spi_continue); else passed++;
      rstn = 1'b1;
      step();
   endtask

   task automatic test_basic_fill();
      lat = 3; remaining = 4; next_data = 16'h1111; data_inc = 16'h1111;
      cont_cnt = 0;
      do_start();
      repeat (40) step();
      total++; if (cont_cnt != 3) $display("FAIL fill_continues: got %0d want 3", cont_cnt); else passed++;
      total++; if (bus.level !== 3'd4) $display("FAIL fill_level: got %0d want 4", bus.level); else passed++;
      total++; if (bus.full !== 1'b1) $display("FAIL fill_full: got %b want 1", bus.full); else passed++;
      total++; if (bus.empty !== 1'b0) $display("FAIL fill_empty: got %b want 0", bus.empty); else passed++;
      total++; if (bus.data_out !== 16'h1111) $display("FAIL fill_head: got %h want 1111", bus.data_out); else passed++;
      total++; if (bus.spi_continue !== 1'b0) $display("FAIL fill_no_continue: got %b want 0", bus.spi_continue); else passed++;
   endtask

   task automatic test_streaming();
      int got, errs, maxlvl;
      logic [15:0] exp;
      do_stop();
      lat = 1; remaining = 64; next_data = 16'h1; data_inc = 16'h1;
      do_start();
      got = 0; errs = 0; maxlvl = 0; exp = 16'h1;
      for (int i = 0; i < 600 && got < 64; i++) begin
         bus.pop = ~bus.empty;
         if (!bus.empty) begin
            if (bus.data_out !== exp) errs++;
            exp = exp + 16'h1;
            got++;
         end
         step();
         if (int'(bus.level) > maxlvl) maxlvl = int'(bus.level);
      end
      bus.pop = 1'b0;
      step();
      total++; if (got != 64) $display("FAIL stream_count: got %0d want 64", got); else passed++;
      total++; if (errs != 0) $display("FAIL stream_order: got %0d bad words want 0", errs); else passed++;
      total++; if (maxlvl > 4) $display("FAIL stream_max_level: got %0d want <=4", maxlvl); else passed++;
      total++; if (bus.empty !== 1'b1) $display("FAIL stream_drained: got %b want 1", bus.empty); else passed++;
   endtask

   task automatic test_wrap();
      int got, errs;
      logic [15:0] exp;
      logic ph;
      do_stop();
      lat = 2; remaining = 10; next_data = 16'h1; data_inc = 16'h1;
      do_start();
      got = 0; errs = 0; exp = 16'h1; ph = 1'b0;
      for (int i = 0; i < 300 && got < 10; i++) begin
         ph = ~ph;
         bus.pop = ph & ~bus.empty;
         if (bus.pop) begin
            if (bus.data_out !== exp) errs++;
            exp = exp + 16'h1;
            got++;
         end
         step();
      end
      bus.pop = 1'b0;
      step();
      total++; if (got != 10) $display("FAIL wrap_count: got %0d want 10", got); else passed++;
      total++; if (errs != 0) $display("FAIL wrap_order: got %0d bad words want 0", errs); else passed++;
      total++; if (bus.empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", bus.empty); else passed++;
      total++; if (bus.level !== 3'd0) $display("FAIL wrap_level: got %0d want 0", bus.level); else passed++;
   endtask

   task automatic test_back_to_back();
      logic found;
      do_stop();
      lat = 3; remaining = 2; next_data = 16'hA001; data_inc = 16'h1;
      do_start();
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         if (delivered && bus.level === 3'd1) found = 1'b1;
      end
      total++; if (found !== 1'b1) $display("FAIL b2b_setup: got %b want 1", found); else passed++;
      total++; if (bus.data_out !== 16'hA001) $display("FAIL b2b_head_before: got %h want a001", bus.data_out); else passed++;
      bus.pop = 1'b1;
      step();
      bus.pop = 1'b0;
      total++; if (bus.level !== 3'd1) $display("FAIL b2b_level: got %0d want 1", bus.level); else passed++;
      total++; if (bus.data_out !== 16'hA002) $display("FAIL b2b_head_after: got %h want a002", bus.data_out); else passed++;
      total++; if (bus.underflow !== 1'b0) $display("FAIL b2b_underflow: got %b want 0", bus.underflow); else passed++;
   endtask

   task automatic test_underflow();
      do_stop();
      remaining = 0;
      bus.pop = 1'b1;
      step();
      bus.pop = 1'b0;
      step();
      total++; if (bus.underflow !== 1'b1) $display("FAIL uf_set: got %b want 1", bus.underflow); else passed++;
      total++; if (bus.level !== 3'd0) $display("FAIL uf_level: got %0d want 0", bus.level); else passed++;
      total++; if (bus.empty !== 1'b1) $display("FAIL uf_empty: got %b want 1", bus.empty); else passed++;
      do_start();
      total++; if (bus.underflow !== 1'b0) $display("FAIL uf_clear: got %b want 0", bus.underflow); else passed++;
   endtask

   task automatic test_stop_pending();
      int lvl_errs, cont_errs, beef;
      do_stop();
      lat = 2; remaining = 1; next_data = 16'hBEEF; data_inc = 16'h0;
      do_start();
      do_stop();
      lvl_errs = 0; cont_errs = 0; beef = 0;
      repeat (8) begin
         step();
         if (bus.level !== 3'd0 || bus.empty !== 1'b1) lvl_errs++;
         if (bus.spi_continue !== 1'b0) cont_errs++;
         if (bus.data_out === 16'hBEEF) beef++;
      end
      total++; if (lvl_errs != 0) $display("FAIL stop_level: got %0d bad cycles want 0", lvl_errs); else passed++;
      total++; if (cont_errs != 0) $display("FAIL stop_continue: got %0d bad cycles want 0", cont_errs); else passed++;
      total++; if (beef != 0) $display("FAIL stop_discard: got %0d beef cycles want 0", beef); else passed++;
      lat = 1; remaining = 4; next_data = 16'h0101; data_inc = 16'h0101;
      do_start();
      repeat (30) step();
      total++; if (bus.level !== 3'd4) $display("FAIL refill_level: got %0d want 4", bus.level); else passed++;
      total++; if (bus.full !== 1'b1) $display("FAIL refill_full: got %b want 1", bus.full); else passed++;
      total++; if (bus.data_out !== 16'h0101) $display("FAIL refill_head: got %h want 0101", bus.data_out); else passed++;
   endtask

   task automatic test_async_reset();
      do_stop();
      lat = 1; remaining = 4; next_data = 16'h0202; data_inc = 16'h0202;
      do_start();
      repeat (4) step();
      total++; if (bus.level === 3'd0) $display("FAIL ar_pre_level: got %0d want nonzero", bus.level); else passed++;
      clk_en = 1'b0;
      #2 rstn = 1'b0;
      #1;
      total++; if (bus.level !== 3'd0) $display("FAIL ar_level: got %0d want 0", bus.level); else passed++;
      total++; if (bus.empty !== 1'b1) $display("FAIL ar_empty: got %b want 1", bus.empty); else passed++;
      total++; if (bus.full !== 1'b0) $display("FAIL ar_full: got %b want 0", bus.full); else passed++;
      total++; if (bus.data_out !== 16'h0) $display("FAIL ar_data: got %h want 0000", bus.data_out); else passed++;
      total++; if (bus.underflow !== 1'b0) $display("FAIL ar_underflow: got %b want 0", bus.underflow); else passed++;
      total++; if (bus.spi_continue !== 1'b0) $display("FAIL ar_continue: got %b want 0", bus.spi_continue); else passed++;
      #2 rstn = 1'b1;
      clk_en = 1'b1;
      repeat (5) step();
      total++; if (bus.level !== 3'd0) $display("FAIL ar_idle_level: got %0d want 0", bus.level); else passed++;
      total++; if (bus.spi_continue !== 1'b0) $display("FAIL ar_idle_continue: got %b want 0", bus.spi_continue); else passed++;
   endtask

   initial begin
      bus.start_read = 1'b0;
      bus.stop_read = 1'b0;
      bus.spi_busy = 1'b0;
      bus.spi_data = 16'h0;
      bus.pop = 1'b0;
      test_reset();
      test_basic_fill();
      test_streaming();
      test_wrap();
      test_back_to_back();
      test_underflow();
      test_stop_pending();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
